// File: rtl/seq_addsub_if.sv
// seq_addsub_if: operand/result handshake bundle for seq_addsub.
// The slave modport is the adder side and the master modport is the producer/consumer side.
interface seq_addsub_if #(
    parameter int unsigned N = 8
) ();
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         neg;

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, result, cout, ovf, zero, neg
    );

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, result, cout, ovf, zero, neg
    );
endinterface

// File: rtl/seq_addsub.sv
// seq_addsub: multi-cycle N-bit adder/subtractor that processes W bits per cycle.
// The carry is held in a register between slices, and the ALU flags are registered
// together with the final slice.
// Optional macro SEQ_ADDSUB_SAT_EN: on signed overflow, the result is clamped to
// signed saturation.
module seq_addsub #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 2
) (
    input logic        clk,
    input logic        rst_n,
    seq_addsub_if.slave bus
);
    localparam int unsigned S  = N / W;
    localparam int unsigned CW = (S > 1) ? $clog2(S) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    generate
        if ((W < 1) || (N < 2) || ((N % W) != 0)) begin : g_bad_cfg
            $error("seq_addsub: invalid configuration N=%0d W=%0d", N, W);
        end
    endgenerate

    logic [1:0]   state;
    logic [CW-1:0] cnt;
    logic [N-1:0] a_reg;
    logic [N-1:0] b_reg;
    logic         carry;
    logic [N-1:0] res_reg;
    logic         cout_reg;
    logic         ovf_reg;
    logic         zero_reg;
    logic         neg_reg;

    logic [W-1:0] a_sl;
    logic [W-1:0] b_sl;
    logic [W:0]   sum;
    logic [N-1:0] res_slice;
    logic [N-1:0] fin;
    logic         last;
    logic         c_msb_in;
    logic         ovf_next;

    // Add the current slice and merge its sum into the running result
    always_comb begin
        a_sl      = '0;
        b_sl      = '0;
        res_slice = res_reg;
        for (int unsigned k = 0; k < S; k++) begin
            if (cnt == CW'(k)) begin
                a_sl = a_reg[k*W +: W];
                b_sl = b_reg[k*W +: W];
            end
        end
        sum = {1'b0, a_sl} + {1'b0, b_sl} + {{W{1'b0}}, carry};
        for (int unsigned k = 0; k < S; k++) begin
            if (cnt == CW'(k)) begin
                res_slice[k*W +: W] = sum[W-1:0];
            end
        end
        last = (cnt == CW'(S - 1));
        // The sum bit is a^b^cin, so the carry into the top bit can be recovered
        // from the top bit of the slice without splitting the adder.
        c_msb_in = a_sl[W-1] ^ b_sl[W-1] ^ sum[W-1];
        ovf_next = c_msb_in ^ sum[W];
`ifdef SEQ_ADDSUB_SAT_EN
        // On overflow, both effective operands share a sign, so a_reg's MSB gives the direction
        if (ovf_next) begin
            fin = a_reg[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end else begin
            fin = res_slice;
        end
`else
        fin = res_slice;
`endif
    end

    // Control FSM, operand capture, slice accumulation and flag registration
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            carry    <= 1'b0;
            res_reg  <= '0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
            zero_reg <= 1'b0;
            neg_reg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg <= bus.a;
                        b_reg <= bus.b ^ {N{bus.sub}};
                        carry <= bus.sub;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    carry   <= sum[W];
                    cnt     <= cnt + CW'(1);
                    res_reg <= res_slice;
                    if (last) begin
                        res_reg  <= fin;
                        cout_reg <= sum[W];
                        ovf_reg  <= ovf_next;
                        zero_reg <= (fin == '0);
                        neg_reg  <= fin[N-1];
                        cnt      <= '0;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = res_reg;
    assign bus.cout      = cout_reg;
    assign bus.ovf       = ovf_reg;
    assign bus.zero      = zero_reg;
    assign bus.neg       = neg_reg;
endmodule

// File: tb/tb_seq_addsub.sv
// tb_seq_addsub: self-checking bench for seq_addsub.
// It runs a W=2 instance and a single-pass (W=N) instance in parallel on shared stimulus.
module tb_seq_addsub;
    localparam int unsigned N = 8;
    localparam int unsigned W = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    seq_addsub_if #(.N(N)) ifc ();
    seq_addsub_if #(.N(N)) if1 ();

    seq_addsub #(.N(N), .W(W)) dut  (.clk(clk), .rst_n(rst_n), .bus(ifc));
    seq_addsub #(.N(N), .W(N)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    assign if1.in_valid  = ifc.in_valid;
    assign if1.a         = ifc.a;
    assign if1.b         = ifc.b;
    assign if1.sub       = ifc.sub;
    assign if1.out_ready = ifc.out_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: {cout, ovf, zero, neg, result} from integer arithmetic
    function automatic logic [N+3:0] model(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
        int sa, sb, t, ua, ub;
        logic c, o;
        logic [N-1:0] r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        ua = int'(a);
        ub = int'(b);
        t  = s ? (sa - sb) : (sa + sb);
        c  = s ? (ua >= ub) : ((ua + ub) >= (1 << N));
        o  = (t > ((1 << (N - 1)) - 1)) || (t < -(1 << (N - 1)));
        r  = N'(t);
`ifdef SEQ_ADDSUB_SAT_EN
        if (o) r = (t > 0) ? N'((1 << (N - 1)) - 1) : N'(1 << (N - 1));
`endif
        return {c, o, (r == '0), r[N-1], r};
    endfunction

    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s, input string tag);
        logic [N+3:0] e;
        int g, lat, lat1;
        e = model(a, b, s);
        g = 0;
        while (ifc.in_ready !== 1'b1 && g < 20) begin tick(); g++; end
        chk({tag, "_rdy"}, 32'(ifc.in_ready), 32'd1);
        ifc.a = a; ifc.b = b; ifc.sub = s; ifc.in_valid = 1'b1;
        tick();
        ifc.in_valid = 1'b0;
        lat = 0; lat1 = 0;
        while (ifc.out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
            if (if1.out_valid === 1'b1 && lat1 == 0) lat1 = lat;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(N / W));
        chk({tag, "_lat1"}, 32'(lat1), 32'd1);
        chk({tag, "_res"}, 32'(ifc.result), 32'(e[N-1:0]));
        chk({tag, "_flags"}, 32'({ifc.cout, ifc.ovf, ifc.zero, ifc.neg}), 32'(e[N+3:N]));
        chk({tag, "_res1"}, 32'(if1.result), 32'(e[N-1:0]));
        chk({tag, "_flags1"}, 32'({if1.cout, if1.ovf, if1.zero, if1.neg}), 32'(e[N+3:N]));
        ifc.out_ready = 1'b1;
        tick();
        ifc.out_ready = 1'b0;
        chk({tag, "_idle"}, 32'({ifc.out_valid, ifc.in_ready, if1.out_valid, if1.in_ready}), 32'b0101);
    endtask

    initial begin
        logic [N+3:0] e;
        int lat, seen;

        // Reset state
        ifc.in_valid = 1'b0; ifc.a = '0; ifc.b = '0; ifc.sub = 1'b0; ifc.out_ready = 1'b0;
        rst_n = 1'b0;
        tick(); tick();
        chk("reset_hs", 32'({ifc.in_ready, ifc.out_valid}), 32'b10);
        chk("reset_out", 32'({ifc.result, ifc.cout, ifc.ovf, ifc.zero, ifc.neg}), 32'd0);
        rst_n = 1'b1;
        tick();

        // Directed arithmetic cases
        do_op(8'h35, 8'h4A, 1'b0, "add_7f");
        do_op(8'h7F, 8'h01, 1'b0, "add_povf");
        do_op(8'h10, 8'h10, 1'b1, "sub_zero");
        do_op(8'h00, 8'h01, 1'b1, "sub_borrow");
        do_op(8'hFF, 8'h01, 1'b0, "add_wrap");
        do_op(8'h80, 8'h01, 1'b1, "sub_novf");
        do_op(8'h80, 8'h80, 1'b0, "add_novf");

        // Backpressure, with new operands offered during RUN and DONE
        e = model(8'h5A, 8'h33, 1'b1);
        ifc.a = 8'h5A; ifc.b = 8'h33; ifc.sub = 1'b1; ifc.in_valid = 1'b1;
        tick();
        ifc.a = 8'hFF; ifc.b = 8'hFF; ifc.sub = 1'b0;
        chk("bp_run_rdy", 32'(ifc.in_ready), 32'd0);
        lat = 0;
        while (ifc.out_valid !== 1'b1 && lat < 20) begin tick(); lat++; end
        chk("bp_lat", 32'(lat), 32'(N / W));
        for (int i = 0; i < 6; i++) begin
            chk("bp_hold", 32'({ifc.out_valid, ifc.in_ready, ifc.cout, ifc.ovf, ifc.zero, ifc.neg, ifc.result}),
                32'({1'b1, 1'b0, e}));
            tick();
        end
        ifc.in_valid = 1'b0;
        ifc.out_ready = 1'b1;
        tick();
        ifc.out_ready = 1'b0;
        chk("bp_release", 32'({ifc.out_valid, ifc.in_ready}), 32'b01);
        do_op(8'h21, 8'h0E, 1'b0, "bp_fresh");

        // Reset during RUN cycle 2
        ifc.a = 8'h12; ifc.b = 8'h34; ifc.sub = 1'b0; ifc.in_valid = 1'b1;
        tick();
        ifc.in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mrst_hs", 32'({ifc.in_ready, ifc.out_valid, if1.in_ready, if1.out_valid}), 32'b1010);
        chk("mrst_res", 32'({ifc.result, if1.result}), 32'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ifc.out_valid === 1'b1 || if1.out_valid === 1'b1) seen++;
        end
        chk("mrst_stale", 32'(seen), 32'd0);
        do_op(8'h44, 8'h45, 1'b1, "mrst_fresh");

        // Randomized operations
        for (int i = 0; i < 24; i++) begin
            do_op(N'($urandom), N'($urandom), 1'($urandom), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
